// File: rtl/reg_lock_file_pkg.sv
// reg_lock_file_pkg: shared widths, types and reset values for the register file and its scoreboard.
package reg_lock_file_pkg;
  localparam int NREG  = 8;
  localparam int WIDTH = 16;
  localparam int CNT_W = 2;
  localparam int AW    = $clog2(NREG);
  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [WIDTH-1:0] reg_value_t;
  typedef enum logic [1:0] {SPEC_SP, SPEC_IH, SPEC_RA} spec_e;
  localparam reg_value_t RST_VAL = '0;
endpackage

// File: rtl/reg_lock_file_lock_counter.sv
// lock_counter: saturating up/down in-flight counter; a simultaneous lock and unlock
// nets to zero change, except that an unlock at zero fails and lets the lock through.
module lock_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic             o_full,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;
  assign o_cnt  = r_cnt;
  assign o_zero = r_cnt == '0;
  assign o_full = &r_cnt;
  assign o_err  = (i_dec && o_zero) || (i_inc && !i_dec && o_full);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc && i_dec && o_zero) r_cnt <= CNT_W'(1);
    else if (i_inc && !i_dec && !o_full) r_cnt <= r_cnt + CNT_W'(1);
    else if (i_dec && !i_inc && !o_zero) r_cnt <= r_cnt - CNT_W'(1);
endmodule

// File: rtl/reg_lock_file.sv
// reg_lock_file: architectural registers R0-R7, SP, IH, RA with write forwarding and a
// per-register in-flight lock scoreboard that stalls decode on busy sources.
module reg_lock_file
  import reg_lock_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_reg_ctrl,
  input  logic [AW-1:0]    write_reg_addr,
  input  logic [WIDTH-1:0] write_reg_data,
  input  logic             unlock_reg,
  input  logic [AW-1:0]    unlock_reg_addr,
  input  logic             wrsp,
  input  logic             wrih,
  input  logic             wrra,
  input  logic [WIDTH-1:0] sp_reg_data,
  input  logic             lock_reg,
  input  logic [AW-1:0]    lock_reg_addr,
  input  logic [AW-1:0]    rd0_addr,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd0_busy,
  output logic             rd1_busy,
  output logic [WIDTH-1:0] sp_out,
  output logic [WIDTH-1:0] ih_out,
  output logic [WIDTH-1:0] ra_out,
  output logic             lock_full,
  output logic             lock_err
);
  reg_value_t       r_regs [NREG];
  reg_value_t       r_sp, r_ih, r_ra;
  logic             r_lock_err;
  logic [CNT_W-1:0] w_cnt [NREG];
  logic [NREG-1:0]  w_inc, w_dec, w_zero, w_full, w_err;
  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    assign w_inc[i] = lock_reg && lock_reg_addr == reg_addr_t'(i);
    assign w_dec[i] = unlock_reg && unlock_reg_addr == reg_addr_t'(i);
    lock_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_inc  (w_inc[i]),
      .i_dec  (w_dec[i]),
      .o_cnt  (w_cnt[i]),
      .o_zero (w_zero[i]),
      .o_full (w_full[i]),
      .o_err  (w_err[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= RST_VAL;
      r_sp       <= RST_VAL;
      r_ih       <= RST_VAL;
      r_ra       <= RST_VAL;
      r_lock_err <= 1'b0;
    end else begin
      if (write_reg_ctrl) r_regs[write_reg_addr] <= write_reg_data;
      if (wrsp) r_sp <= sp_reg_data;
      if (wrih) r_ih <= sp_reg_data;
      if (wrra) r_ra <= sp_reg_data;
      r_lock_err <= r_lock_err | (|w_err);
    end
  assign rd0_data = write_reg_ctrl && rd0_addr == write_reg_addr ? write_reg_data : r_regs[rd0_addr];
  assign rd1_data = write_reg_ctrl && rd1_addr == write_reg_addr ? write_reg_data : r_regs[rd1_addr];
  // A source whose last lock is released this cycle is already free.
  assign rd0_busy = !w_zero[rd0_addr] && !(w_dec[rd0_addr] && w_cnt[rd0_addr] == CNT_W'(1));
  assign rd1_busy = !w_zero[rd1_addr] && !(w_dec[rd1_addr] && w_cnt[rd1_addr] == CNT_W'(1));
  assign sp_out    = wrsp ? sp_reg_data : r_sp;
  assign ih_out    = wrih ? sp_reg_data : r_ih;
  assign ra_out    = wrra ? sp_reg_data : r_ra;
  assign lock_full = lock_reg && w_full[lock_reg_addr] && !w_dec[lock_reg_addr];
  assign lock_err  = r_lock_err;
endmodule

// File: tb/tb_reg_lock_file.sv
// tb_reg_lock_file: directed and random stimulus; expectations from an arithmetic model
// are queued per cycle and compared by an independent monitor.
module tb_reg_lock_file;
  typedef struct {
    logic rst_n, wc, ul, wrsp, wrih, wrra, lk;
    logic [2:0] wa, ua, la, r0, r1;
    logic [15:0] wd, spd;
  } stim_t;
  typedef struct {
    int id;
    logic [15:0] d0, d1, sp, ih, ra;
    logic b0, b1, full, err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, write_reg_ctrl, unlock_reg, wrsp, wrih, wrra, lock_reg;
  logic [2:0] write_reg_addr, unlock_reg_addr, lock_reg_addr, rd0_addr, rd1_addr;
  logic [15:0] write_reg_data, sp_reg_data;
  logic [15:0] rd0_data, rd1_data, sp_out, ih_out, ra_out;
  logic rd0_busy, rd1_busy, lock_full, lock_err;
  exp_t q[$];
  int n_tests = 0, n_fail = 0, n_step = 0;
  logic [15:0] m_r[8];
  int m_c[8];
  logic [15:0] m_sp, m_ih, m_ra;
  logic m_err;
  reg_lock_file dut (
    .clk(clk), .rst_n(rst_n),
    .write_reg_ctrl(write_reg_ctrl), .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
    .unlock_reg(unlock_reg), .unlock_reg_addr(unlock_reg_addr),
    .wrsp(wrsp), .wrih(wrih), .wrra(wrra), .sp_reg_data(sp_reg_data),
    .lock_reg(lock_reg), .lock_reg_addr(lock_reg_addr),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_data(rd0_data), .rd1_data(rd1_data), .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .sp_out(sp_out), .ih_out(ih_out), .ra_out(ra_out),
    .lock_full(lock_full), .lock_err(lock_err)
  );
  always #5 clk = ~clk;
  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, wc: 1'b0, ul: 1'b0, wrsp: 1'b0, wrih: 1'b0, wrra: 1'b0, lk: 1'b0,
          wa: 3'd0, ua: 3'd0, la: 3'd0, r0: 3'd0, r1: 3'd0, wd: 16'h0, spd: 16'h0};
    return s;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_r[i] = 16'h0; m_c[i] = 0; end
    m_sp = 16'h0; m_ih = 16'h0; m_ra = 16'h0; m_err = 1'b0;
  endtask
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n = s.rst_n; write_reg_ctrl = s.wc; write_reg_addr = s.wa; write_reg_data = s.wd;
    unlock_reg = s.ul; unlock_reg_addr = s.ua; wrsp = s.wrsp; wrih = s.wrih; wrra = s.wrra;
    sp_reg_data = s.spd; lock_reg = s.lk; lock_reg_addr = s.la; rd0_addr = s.r0; rd1_addr = s.r1;
    if (!s.rst_n) model_reset();
    e.id   = n_step++;
    e.d0   = (s.wc && s.r0 == s.wa) ? s.wd : m_r[s.r0];
    e.d1   = (s.wc && s.r1 == s.wa) ? s.wd : m_r[s.r1];
    e.b0   = m_c[s.r0] - int'(s.ul && s.ua == s.r0) > 0;
    e.b1   = m_c[s.r1] - int'(s.ul && s.ua == s.r1) > 0;
    e.sp   = s.wrsp ? s.spd : m_sp;
    e.ih   = s.wrih ? s.spd : m_ih;
    e.ra   = s.wrra ? s.spd : m_ra;
    e.full = s.lk && m_c[s.la] == 3 && !(s.ul && s.ua == s.la);
    e.err  = m_err;
    q.push_back(e);
    if (s.rst_n) begin
      if (s.wc) m_r[s.wa] = s.wd;
      if (s.wrsp) m_sp = s.spd;
      if (s.wrih) m_ih = s.spd;
      if (s.wrra) m_ra = s.spd;
      if (s.ul) begin
        if (m_c[s.ua] == 0) m_err = 1'b1;
        else m_c[s.ua]--;
      end
      if (s.lk) begin
        if (m_c[s.la] == 3) m_err = 1'b1;
        else m_c[s.la]++;
      end
    end
  endtask
  task automatic chk(input string n, input int id, input logic [15:0] a, input logic [15:0] x);
    n_tests++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", n, id, a, x);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rd0_data", e.id, rd0_data, e.d0);
        chk("rd1_data", e.id, rd1_data, e.d1);
        chk("rd0_busy", e.id, {15'b0, rd0_busy}, {15'b0, e.b0});
        chk("rd1_busy", e.id, {15'b0, rd1_busy}, {15'b0, e.b1});
        chk("sp_out", e.id, sp_out, e.sp);
        chk("ih_out", e.id, ih_out, e.ih);
        chk("ra_out", e.id, ra_out, e.ra);
        chk("lock_full", e.id, {15'b0, lock_full}, {15'b0, e.full});
        chk("lock_err", e.id, {15'b0, lock_err}, {15'b0, e.err});
      end
    end
  end
  initial begin
    stim_t s;
    model_reset();
    s = idle(); s.rst_n = 1'b0; step(s);
    s = idle(); step(s);
    s = idle(); s.wc = 1; s.wa = 3; s.wd = 16'h1234; s.r0 = 3; step(s);
    s = idle(); s.lk = 1; s.la = 3; s.r0 = 3; s.r1 = 3; step(s);
    s = idle(); s.r0 = 3; s.r1 = 3; step(s);
    s = idle(); s.rst_n = 1'b0; s.r0 = 3; s.r1 = 3; step(s);
    s = idle(); s.r0 = 3; s.r1 = 3; step(s);
    s = idle(); s.wc = 1; s.wa = 5; s.wd = 16'hBEEF; s.r0 = 5; step(s);
    s = idle(); s.r0 = 5; step(s);
    for (int i = 0; i < 2; i++) begin s = idle(); s.lk = 1; s.la = 2; s.r1 = 2; step(s); end
    for (int i = 0; i < 3; i++) begin s = idle(); s.ul = i > 0; s.ua = 2; s.r1 = 2; step(s); end
    s = idle(); s.r1 = 2; step(s);
    for (int i = 0; i < 4; i++) begin s = idle(); s.lk = 1; s.la = 7; s.r0 = 7; step(s); end
    s = idle(); s.r0 = 7; step(s);
    s = idle(); s.lk = 1; s.la = 7; s.ul = 1; s.ua = 7; s.r0 = 7; step(s);
    s = idle(); s.lk = 1; s.la = 7; s.r0 = 7; step(s);
    s = idle(); s.rst_n = 1'b0; step(s);
    s = idle(); s.r0 = 1; step(s);
    s = idle(); s.ul = 1; s.ua = 1; s.r0 = 1; step(s);
    s = idle(); s.r0 = 1; step(s);
    s = idle(); s.ul = 1; s.ua = 1; s.lk = 1; s.la = 1; s.r0 = 1; step(s);
    s = idle(); s.r0 = 1; step(s);
    s = idle(); s.wrsp = 1; s.wrra = 1; s.spd = 16'hBF00; step(s);
    s = idle(); step(s);
    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.rst_n = $urandom_range(0, 99) != 0;
      s.wc = $urandom_range(0, 1) != 0; s.wa = 3'($urandom_range(0, 7)); s.wd = 16'($urandom);
      s.ul = $urandom_range(0, 9) < 4; s.ua = 3'($urandom_range(0, 3));
      s.lk = $urandom_range(0, 9) < 5; s.la = 3'($urandom_range(0, 3));
      s.wrsp = $urandom_range(0, 4) == 0; s.wrih = $urandom_range(0, 4) == 0;
      s.wrra = $urandom_range(0, 4) == 0; s.spd = 16'($urandom);
      s.r0 = 3'($urandom_range(0, 7)); s.r1 = 3'($urandom_range(0, 7));
      step(s);
    end
    s = idle(); step(s);
    repeat (3) @(negedge clk);
    #4;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
